// File: rtl/mm_pkg.sv
// Shared types and constants for the GEMM tile scheduler and its result buffer.
package mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BADCMD  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int RES_W       = 32;
  localparam int CORE_SIZE_W = 17;

endpackage

// File: rtl/mm_result_buffer.sv
// Captures the four C results of one 2x2 tile and drains them to the
// memory write port in C11, C12, C21, C22 order.
module mm_result_buffer
  import mm_pkg::*;
#(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture_en,
  input  logic [3:0]           core_rdy,
  input  logic [4*RES_W-1:0]   core_res,
  input  logic                 drain_en,
  input  logic [ADDR_W-1:0]    base,
  input  logic [DIM_W-1:0]     n,
  input  logic [DIM_W-1:0]     tile_row,
  input  logic [DIM_W-1:0]     tile_col,
  input  logic                 wr_ready,
  output logic                 wr_valid,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [RES_W-1:0]     wr_data,
  output logic                 wr_last
);

  logic signed [RES_W-1:0] slot [4];
  logic [1:0]              idx;
  logic [ADDR_W-1:0]       row_a, col_a, n_a, c11, c21, addr_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) slot[i] <= '0;
      idx <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (capture_en && core_rdy[i]) slot[i] <= signed'(core_res[i*RES_W +: RES_W]);
      // Two-bit index wraps to 0 after the fourth word, ready for the next tile.
      if (drain_en && wr_ready) idx <= idx + 2'd1;
    end
  end

  assign row_a = ADDR_W'({tile_row, 1'b0});
  assign col_a = ADDR_W'({tile_col, 1'b0});
  assign n_a   = ADDR_W'(n);
  assign c11   = base + ((row_a * n_a + col_a) << 2);
  assign c21   = c11 + (n_a << 2);

  always_comb begin
    addr_sel = c11;
    case (idx)
      2'd0: addr_sel = c11;
      2'd1: addr_sel = c11 + ADDR_W'(4);
      2'd2: addr_sel = c21;
      2'd3: addr_sel = c21 + ADDR_W'(4);
      default: addr_sel = c11;
    endcase
  end

  assign wr_valid = drain_en;
  assign wr_addr  = drain_en ? addr_sel : '0;
  assign wr_data  = drain_en ? slot[idx] : '0;
  assign wr_last  = drain_en && wr_ready && (idx == 2'd3);

endmodule

// File: rtl/mm_tile_scheduler.sv
// Walks the 2x2 output tiles of an M x N GEMM row-major, driving the systolic
// core per tile and streaming each tile's results to memory.
module mm_tile_scheduler
  import mm_pkg::*;
#(
  parameter int DIM_W   = 16,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [DIM_W-1:0]              cmd_m,
  input  logic [DIM_W-1:0]              cmd_n,
  input  logic [DIM_W-1:0]              cmd_k,
  input  logic [ADDR_W-1:0]             cmd_c_base,
  output logic                          core_start,
  output logic signed [CORE_SIZE_W-1:0] core_size,
  output logic [DIM_W-1:0]              tile_row,
  output logic [DIM_W-1:0]              tile_col,
  input  logic [3:0]                    core_rdy,
  input  logic [4*RES_W-1:0]            core_res,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [RES_W-1:0]              wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    err_code
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t              state, state_nxt;
  logic [DIM_W-1:0]    m_q, n_q, k_q;
  logic [ADDR_W-1:0]   base_q;
  logic [WD_W-1:0]     wdog;
  logic [1:0]          err_code_q;
  logic                err_q;
  logic                bad_cmd, col_last, row_last, last_tile, timeout_hit, wr_last;

  assign bad_cmd     = m_q[0] || (m_q == '0) || n_q[0] || (n_q == '0) || (k_q == '0);
  assign col_last    = tile_col == (n_q >> 1) - DIM_W'(1);
  assign row_last    = tile_row == (m_q >> 1) - DIM_W'(1);
  assign last_tile   = col_last && row_last;
  // wdog holds the number of cycles elapsed since core_start.
  assign timeout_hit = wdog == WD_W'(TIMEOUT - 1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_CHECK;
      S_CHECK: state_nxt = bad_cmd ? S_DONE : S_START;
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (core_rdy[3])      state_nxt = S_DRAIN;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_DRAIN: if (wr_last) state_nxt = last_tile ? S_DONE : S_START;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      m_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      base_q     <= '0;
      tile_row   <= '0;
      tile_col   <= '0;
      wdog       <= '0;
      err_code_q <= ERR_NONE;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (cmd_valid) begin
          m_q        <= cmd_m;
          n_q        <= cmd_n;
          k_q        <= cmd_k;
          base_q     <= cmd_c_base;
          err_code_q <= ERR_NONE;
          err_q      <= 1'b0;
        end
        S_CHECK: begin
          if (bad_cmd) err_code_q <= ERR_BADCMD;
          tile_row <= '0;
          tile_col <= '0;
        end
        S_START: wdog <= WD_W'(1);
        S_RUN: begin
          wdog <= wdog + WD_W'(1);
          if (!core_rdy[3] && timeout_hit) err_code_q <= ERR_TIMEOUT;
        end
        S_DRAIN: if (wr_last && !last_tile) begin
          if (col_last) begin
            tile_col <= '0;
            tile_row <= tile_row + DIM_W'(1);
          end else begin
            tile_col <= tile_col + DIM_W'(1);
          end
        end
        S_DONE: err_q <= (err_code_q != ERR_NONE);
        default: ;
      endcase
    end
  end

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign core_start = (state == S_START);
  assign done       = (state == S_DONE);
  assign core_size  = signed'(CORE_SIZE_W'(k_q));
  assign err        = err_q;
  assign err_code   = err_code_q;

  mm_result_buffer #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .capture_en (state == S_RUN),
    .core_rdy   (core_rdy),
    .core_res   (core_res),
    .drain_en   (state == S_DRAIN),
    .base       (base_q),
    .n          (n_q),
    .tile_row   (tile_row),
    .tile_col   (tile_col),
    .wr_ready   (wr_ready),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_last    (wr_last)
  );

endmodule
